// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb_if
//  Description : Bundle between the byte sources, the UART transmitter arbiter
//                and uart_top's transmit strobe/busy handshake.
//                The slave modport is the arbiter's view. The master modport
//                is the sources' and transmitter's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arb_if #(
  parameter int NREQ = 2,
  parameter int DW   = 8,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_ready;
  logic [DW-1:0]      o_tx_data;
  logic               o_tx_stb;
  logic               i_tx_busy;
  logic [GW-1:0]      o_grant_id;
  logic               o_active;

  modport slave (
    input  i_req_valid, i_req_data, i_tx_busy,
    output o_req_ready, o_tx_data, o_tx_stb, o_grant_id, o_active
  );

  modport master (
    output i_req_valid, i_req_data, i_tx_busy,
    input  o_req_ready, o_tx_data, o_tx_stb, o_grant_id, o_active
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Shares one UART transmitter between NREQ byte sources.
//                Each source has a one-entry holding buffer. Full buffers are
//                granted round-robin. Each grant produces one send strobe and
//                then follows the transmitter's busy handshake, with a
//                timeout if busy never rises.
//                Optional build macro UART_TX_ARB_PRIO_EN selects fixed
//                priority, where the lowest index wins. Round-robin is the
//                default.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
  parameter int NREQ     = 2,
  parameter int DW       = 8,
  parameter int START_TO = 15
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  localparam int c_gw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cw = $clog2(START_TO + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_full;
  logic [DW-1:0]     r_buf [NREQ];
  logic [DW-1:0]     r_tx_data;
  logic              r_tx_stb;
  logic [c_gw-1:0]   r_grant_id;
  logic [c_cw-1:0]   r_cnt;

  logic              w_pick_vld;
  logic [c_gw-1:0]   w_pick_idx;
  logic              w_grant;
  logic [NREQ-1:0]   w_clr;

`ifndef UART_TX_ARB_PRIO_EN
  logic [c_gw-1:0]   r_ptr;
  logic [c_gw-1:0]   w_slot;
`endif

  // Choose the buffer to serve next. Iterating from the far end lets the
  // nearest full candidate overwrite the others, so it wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
`ifdef UART_TX_ARB_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r_full[i]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = c_gw'(i);
      end
    end
`else
    w_slot = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_slot = c_gw'((int'(r_ptr) + k) % NREQ);
      if (r_full[w_slot]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_slot;
      end
    end
`endif
  end

  // A grant happens only from IDLE with a full buffer and an idle transmitter.
  assign w_grant = (r_state == IDLE) && w_pick_vld && !bus.i_tx_busy;

  // Build a one-hot mask that empties the granted buffer.
  always_comb begin
    w_clr = '0;
    if (w_grant) w_clr[w_pick_idx] = 1'b1;
  end

  // Update the holding buffers. A buffer captures only while empty and is
  // granted only while full, so the capture and clear branches are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
      for (int i = 0; i < NREQ; i++) r_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.i_req_valid[i] && !r_full[i]) begin
          r_full[i] <= 1'b1;
          r_buf[i]  <= bus.i_req_data[i*DW +: DW];
        end else if (w_clr[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Run the transmit sequencer. It registers one strobe per grant, waits for
  // busy to rise (with a timeout), then waits for busy to fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_data  <= '0;
      r_tx_stb   <= 1'b0;
      r_grant_id <= '0;
      r_cnt      <= '0;
`ifndef UART_TX_ARB_PRIO_EN
      r_ptr      <= c_gw'(NREQ - 1);
`endif
    end else begin
      r_tx_stb <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_tx_data  <= r_buf[w_pick_idx];
            r_tx_stb   <= 1'b1;
            r_grant_id <= w_pick_idx;
            r_cnt      <= '0;
            r_state    <= WAIT_START;
`ifndef UART_TX_ARB_PRIO_EN
            r_ptr      <= w_pick_idx;
`endif
          end
        end
        WAIT_START: begin
          // A missing busy response is treated as a completed send, with no
          // retry.
          if (bus.i_tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == c_cw'(START_TO - 1)) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.i_tx_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = ~r_full;
  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_stb    = r_tx_stb;
  assign bus.o_grant_id  = r_grant_id;
  assign bus.o_active    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Directed self-checking bench for uart_tx_arb (NREQ=2, DW=8,
//                START_TO=15). Expected values are hand-derived per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arb;
  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .DW(DW), .START_TO(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Strobe log: data, grant id and cycle of every observed strobe
  logic [7:0] stb_data[$];
  int         stb_id[$];
  int         stb_cyc[$];

  // Busy model: busy high for bm_hold cycles starting bm_delay after a strobe
  bit bm_en;
  int bm_delay, bm_hold, bm_rise;

  // Streaming sources: requester i sends base[i]+0 .. base[i]+5
  bit         src_en;
  int         src_idx[NREQ];
  logic [7:0] src_base[NREQ];

  // Advance one clock; sample #1 after the edge, then drive the next inputs
  task automatic step();
    logic [NREQ-1:0] acc;
    acc = bus.i_req_valid & bus.o_req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (src_en)
      for (int i = 0; i < NREQ; i++) if (acc[i]) src_idx[i]++;
    if (bus.o_tx_stb === 1'b1) begin
      stb_data.push_back(bus.o_tx_data);
      stb_id.push_back(int'(bus.o_grant_id));
      stb_cyc.push_back(cyc);
      checks++;
      if (bus.i_tx_busy !== 1'b0)
        $display("FAIL stb_while_busy cyc=%0d busy=%b required 0", cyc, bus.i_tx_busy);
      else passed++;
      if (bm_en) bm_rise = cyc + bm_delay;
    end
    if (bm_en) bus.i_tx_busy = (cyc >= bm_rise) && (cyc < bm_rise + bm_hold);
    if (src_en)
      for (int i = 0; i < NREQ; i++) begin
        bus.i_req_valid[i]         = (src_idx[i] < 6);
        bus.i_req_data[i*DW +: DW] = src_base[i] + 8'(src_idx[i]);
      end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_tx_busy   = 1'b0;
    bm_en   = 1'b0;
    bm_rise = -1000;
    src_en  = 1'b0;
    stb_data.delete();
    stb_id.delete();
    stb_cyc.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && bus.o_active !== 1'b0; i++) step();
    checks++;
    if (bus.o_active !== 1'b0) $display("FAIL wait_idle timeout active=%b required 0", bus.o_active);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.o_req_ready, bus.o_tx_data, bus.o_tx_stb, bus.o_grant_id, bus.o_active} !== {2'b11, 8'h00, 3'b000})
      $display("FAIL reset_values ready=%b data=%h stb=%b id=%0d act=%b required 11/00/0/0/0",
               bus.o_req_ready, bus.o_tx_data, bus.o_tx_stb, bus.o_grant_id, bus.o_active);
    else passed++;
  endtask

  // Test 1: single byte, strobe one cycle after capture
  task automatic test_single();
    do_reset();
    bus.i_req_valid[0]  = 1'b1;
    bus.i_req_data[7:0] = 8'h41;
    step();
    bus.i_req_valid[0] = 1'b0;
    checks++;
    if ({bus.o_req_ready[0], bus.o_tx_stb} !== 2'b00)
      $display("FAIL single_capture ready0=%b stb=%b required 0/0", bus.o_req_ready[0], bus.o_tx_stb);
    else passed++;
    step();
    checks++;
    if ({bus.o_tx_stb, bus.o_tx_data, bus.o_grant_id, bus.o_req_ready[0], bus.o_active} !== {1'b1, 8'h41, 1'b0, 1'b1, 1'b1})
      $display("FAIL single_strobe stb=%b data=%h id=%0d ready0=%b act=%b required 1/41/0/1/1",
               bus.o_tx_stb, bus.o_tx_data, bus.o_grant_id, bus.o_req_ready[0], bus.o_active);
    else passed++;
    step();
    checks++;
    if ({bus.o_tx_stb, bus.o_tx_data} !== {1'b0, 8'h41})
      $display("FAIL single_stb_width stb=%b data=%h required 0/41", bus.o_tx_stb, bus.o_tx_data);
    else passed++;
    wait_idle();
  endtask

  // Test 2: two simultaneous bytes with a busy model (rise +2, hold 50)
  task automatic test_two();
    int c0;
    do_reset();
    bm_en = 1'b1; bm_delay = 2; bm_hold = 50;
    bus.i_req_valid = 2'b11;
    bus.i_req_data  = 16'h2010;
    step();
    c0 = cyc;
    bus.i_req_valid = 2'b00;
    for (int i = 0; i < 300 && stb_data.size() < 2; i++) step();
    checks++;
    if (stb_data.size() != 2) $display("FAIL two_count got=%0d required 2", stb_data.size());
    else begin
      passed++;
      checks++;
      if (stb_cyc[0] != c0 + 1) $display("FAIL two_latency got=%0d required %0d", stb_cyc[0], c0 + 1);
      else passed++;
      checks++;
      if ({stb_data[0], stb_id[0][0], stb_data[1], stb_id[1][0]} !== {8'h10, 1'b0, 8'h20, 1'b1})
        $display("FAIL two_order got=%h/%0d,%h/%0d required 10/0,20/1", stb_data[0], stb_id[0], stb_data[1], stb_id[1]);
      else passed++;
      // Busy is first low in cycle s0+52; WAIT_DONE samples it, IDLE follows,
      // and the registered strobe appears one cycle after that: s0+54.
      checks++;
      if (stb_cyc[1] != stb_cyc[0] + 54)
        $display("FAIL two_gap got=%0d required %0d", stb_cyc[1] - stb_cyc[0], 54);
      else passed++;
    end
    wait_idle();
  endtask

  // Test 3: both requesters stream 6 bytes each
  task automatic test_stream();
    int exp_id, exp_k;
    do_reset();
    bm_en = 1'b1; bm_delay = 2; bm_hold = 4;
    src_en = 1'b1;
    src_base[0] = 8'hA0; src_base[1] = 8'hB0;
    src_idx[0] = 0; src_idx[1] = 0;
    bus.i_req_valid = 2'b11;
    bus.i_req_data  = 16'hB0A0;
    for (int i = 0; i < 2000 && stb_data.size() < 12; i++) step();
    checks++;
    if (stb_data.size() != 12) $display("FAIL stream_count got=%0d required 12", stb_data.size());
    else begin
      passed++;
      for (int n = 0; n < 12; n++) begin
`ifdef UART_TX_ARB_PRIO_EN
        exp_id = (n < 6) ? 0 : 1;
        exp_k  = n % 6;
`else
        exp_id = n % 2;
        exp_k  = n / 2;
`endif
        checks++;
        if (stb_id[n] != exp_id) $display("FAIL stream_id n=%0d got=%0d required %0d", n, stb_id[n], exp_id);
        else passed++;
        checks++;
        if (stb_data[n] !== src_base[exp_id] + 8'(exp_k))
          $display("FAIL stream_data n=%0d got=%h required %h", n, stb_data[n], src_base[exp_id] + 8'(exp_k));
        else passed++;
      end
    end
    src_en = 1'b0;
    bus.i_req_valid = 2'b00;
    wait_idle();
  endtask

  // Test 4: busy never rises; timeout after START_TO cycles, then next strobe
  task automatic test_timeout();
    int t_idle;
    t_idle = -1;
    do_reset();
    bus.i_req_valid = 2'b11;
    bus.i_req_data  = 16'h2211;
    step();
    bus.i_req_valid = 2'b00;
    for (int i = 0; i < 100 && stb_data.size() < 2; i++) begin
      step();
      if (stb_cyc.size() >= 1 && t_idle < 0 && bus.o_active === 1'b0) t_idle = cyc;
    end
    checks++;
    if (stb_data.size() != 2) $display("FAIL timeout_count got=%0d required 2", stb_data.size());
    else begin
      passed++;
      checks++;
      if (t_idle != stb_cyc[0] + TO) $display("FAIL timeout_idle got=%0d required %0d", t_idle - stb_cyc[0], TO);
      else passed++;
      checks++;
      if (stb_cyc[1] != stb_cyc[0] + TO + 1)
        $display("FAIL timeout_next got=%0d required %0d", stb_cyc[1] - stb_cyc[0], TO + 1);
      else passed++;
      checks++;
      if ({stb_data[1], stb_id[1][0]} !== {8'h22, 1'b1})
        $display("FAIL timeout_data got=%h/%0d required 22/1", stb_data[1], stb_id[1]);
      else passed++;
    end
    wait_idle();
  endtask

  // Test 5: asynchronous reset while in WAIT_DONE with buffer 1 still full
  task automatic test_reset_mid();
    do_reset();
    bm_en = 1'b1; bm_delay = 2; bm_hold = 50;
    bus.i_req_valid = 2'b11;
    bus.i_req_data  = 16'h3C10;
    step();
    bus.i_req_valid = 2'b00;
    repeat (10) step();
    checks++;
    if ({bus.o_req_ready, bus.o_active, bus.o_tx_data} !== {2'b01, 1'b1, 8'h10})
      $display("FAIL mid_pre ready=%b act=%b data=%h required 01/1/10", bus.o_req_ready, bus.o_active, bus.o_tx_data);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_req_ready, bus.o_tx_data, bus.o_tx_stb, bus.o_grant_id, bus.o_active} !== {2'b11, 8'h00, 3'b000})
      $display("FAIL mid_async ready=%b data=%h stb=%b id=%0d act=%b required 11/00/0/0/0",
               bus.o_req_ready, bus.o_tx_data, bus.o_tx_stb, bus.o_grant_id, bus.o_active);
    else passed++;
    bm_en = 1'b0;
    bus.i_tx_busy = 1'b0;
    stb_data.delete(); stb_id.delete(); stb_cyc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) step();
    checks++;
    if (stb_data.size() != 0) $display("FAIL mid_no_strobe got=%0d strobes required 0", stb_data.size());
    else passed++;
    bus.i_req_valid[1]   = 1'b1;
    bus.i_req_data[15:8] = 8'h55;
    step();
    bus.i_req_valid = 2'b00;
    step();
    checks++;
    if ({bus.o_tx_stb, bus.o_tx_data, bus.o_grant_id} !== {1'b1, 8'h55, 1'b1})
      $display("FAIL mid_new_byte stb=%b data=%h id=%0d required 1/55/1", bus.o_tx_stb, bus.o_tx_data, bus.o_grant_id);
    else passed++;
    wait_idle();
  endtask

  // Test 6: busy held high in IDLE delays the strobe until it drops
  task automatic test_busy_hold();
    do_reset();
    bus.i_tx_busy       = 1'b1;
    bus.i_req_valid[0]  = 1'b1;
    bus.i_req_data[7:0] = 8'h66;
    step();
    bus.i_req_valid = 2'b00;
    repeat (10) step();
    checks++;
    if ({stb_data.size() == 0, bus.o_req_ready[0], bus.o_active} !== 3'b100)
      $display("FAIL hold_no_strobe strobes=%0d ready0=%b act=%b required 0/0/0",
               stb_data.size(), bus.o_req_ready[0], bus.o_active);
    else passed++;
    bus.i_tx_busy = 1'b0;
    step();
    checks++;
    if ({bus.o_tx_stb, bus.o_tx_data, bus.o_grant_id} !== {1'b1, 8'h66, 1'b0})
      $display("FAIL hold_release stb=%b data=%h id=%0d required 1/66/0", bus.o_tx_stb, bus.o_tx_data, bus.o_grant_id);
    else passed++;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_stream();
    test_timeout();
    test_reset_mid();
    test_busy_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares the single UART transmitter (uart_top i_tx_data / i_tx_stb / o_tx_busy) between NREQ independent byte sources, e.g. the sequencer and a button-driven debug/status source.
- Each requester gets a one-entry holding buffer. Buffers are granted round-robin.
- The block issues one strobe per byte and sequences the busy handshake, so no requester ever strobes into a busy transmitter.
- Sits between the sources and uart_top in the nexys3 top level.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 8, data width per byte.
- START_TO, 15, cycles to wait for i_tx_busy to rise after a strobe before giving up (1..255).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester byte valid.
- i_req_data  in  NREQ*DW  requester i data occupies bits [i*DW +: DW].
- o_req_ready  out  NREQ  per-requester buffer empty; a byte is accepted when valid & ready.
- o_tx_data  out  DW  to uart_top i_tx_data.
- o_tx_stb  out  1  one-cycle send strobe, to uart_top i_tx_stb.
- i_tx_busy  in  1  from uart_top o_tx_busy.
- o_grant_id  out  clog2(NREQ), min 1  index of the requester whose byte was last sent.
- o_active  out  1  high whenever state != IDLE.

Behaviour:
Reset (async assert, any state):
- All buffers empty, so o_req_ready = all 1s.
- o_tx_data = 0, o_tx_stb = 0, o_grant_id = 0, o_active = 0.
- Round-robin pointer = NREQ-1, so requester 0 is served first. State = IDLE.
- A reset mid-transfer discards all buffered bytes. A byte already strobed into the UART finishes on its own.

Capture:
- When i_req_valid[i] & o_req_ready[i], buffer i loads i_req_data slice i and becomes full.
- o_req_ready[i] drops the next cycle.
- Registered ready, no combinational path from valid to ready.

FSM:
- IDLE: if any buffer is full and i_tx_busy = 0:
  - pick the first full buffer searching from pointer+1 upward, wrapping at NREQ;
  - register o_tx_data = that buffer's data, o_tx_stb = 1 for exactly one cycle, o_grant_id = index;
  - pointer = index, and clear that buffer so its ready rises the next cycle;
  - go to WAIT_START.
  If i_tx_busy = 1 in IDLE, hold off with no strobe.
- WAIT_START: count cycles.
  - i_tx_busy = 1 -> WAIT_DONE.
  - START_TO cycles elapse without busy -> IDLE. The byte is considered sent and no retry is made.
- WAIT_DONE: i_tx_busy = 0 -> IDLE.

Timing and boundary rules:
- Grant-to-strobe latency is 1 cycle from buffer full, i.e. strobe in the cycle after capture when idle.
- The next strobe comes no earlier than 1 cycle after i_tx_busy falls.
- o_tx_data holds its value from the strobe until the next grant.
- Capture and grant never hit the same buffer in one cycle: grant needs full, capture needs empty.
- A requester may refill in the cycle after its grant. That byte waits for the current transfer to finish.
- Simultaneous full buffers are served strictly round-robin, one byte each.
- A requester that holds valid continuously gets at most 1 of every NREQ slots while others are pending.
- Pointer wrap-around: after index NREQ-1, the search starts at 0.
- The WAIT_START counter is wide enough for START_TO and resets to 0 on each strobe.

Optional Feature:
- Macro UART_TX_ARB_PRIO_EN.
- Defined: fixed priority. The lowest-index full buffer always wins, the pointer is unused, and o_grant_id is still reported.
- Undefined (default): round-robin as above.
- Handshake, timeout and reset behaviour are identical in both builds.

Test Plan:
1. Reset, then load requester 0 with 0x41 while idle and busy = 0:
   - o_tx_stb is high exactly 1 cycle, the cycle after capture, with o_tx_data = 0x41 and o_grant_id = 0;
   - ready[0] returns high the next cycle.
2. Load both buffers in the same cycle (req0 = 0x10, req1 = 0x20). The busy model asserts 2 cycles after the strobe and holds 50 cycles:
   - strobes in the order 0x10 then 0x20;
   - the second strobe comes 1 cycle after busy falls;
   - there is never a strobe while busy = 1.
3. Both requesters stream continuously, 6 bytes each:
   - round-robin build: grant sequence 0,1,0,1,0,1,...;
   - UART_TX_ARB_PRIO_EN build: all 6 of req0 are sent before any req1.
4. Busy is never asserted after the strobe:
   - the FSM returns to IDLE after exactly START_TO = 15 cycles in WAIT_START;
   - the next pending byte is strobed in the following cycle.
5. Assert rst in WAIT_DONE with buffer 1 full:
   - all outputs reach their reset values immediately (asynchronously);
   - ready = all 1s, and no strobe occurs after release until a new capture.
6. i_tx_busy is held 1 in IDLE while buffer 0 is full:
   - no strobe;
   - the strobe occurs the cycle after busy drops.
